// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - T-state control sequencer for the 8-bit CPU
//
// Purpose:
//   Fetches an instruction byte, decodes its opcode and steps a T0..T5 FSM
//   (plus HALT). The FSM drives the bus strobes and the ALU select/enable.
//   The ALU zero and carry flags are latched here for JC/JZ, because the ALU
//   recomputes its zero flag on every clock.
//
// Ports:
//   clk         in   1          system clock, all state on posedge
//   rst         in   1          synchronous, active-high reset
//   step_req    in   1          single-step request (only with MSEQ_SINGLE_STEP_EN)
//   instr       in   DATA_SIZE  instruction register contents
//   flag_zero   in   1          ALU zero flag
//   flag_carry  in   1          ALU carry flag
//   ctrl        out  12         {out_in,b_in,a_out,a_in,ir_out,ir_in,
//                                ram_in,ram_out,mar_in,pc_load,pc_inc,pc_out}
//   alu_select  out  5          ALU operation code
//   alu_en      out  1          ALU drives the bus
//   halted      out  1          1 while in HALT
//
// Configuration:
//   MSEQ_SINGLE_STEP_EN - when defined, every T0 is held (strobes low) until
//   step_req=1 is sampled; T0 then executes on the following cycle.

module micro_sequencer #(
  parameter int DATA_SIZE = 8,
  parameter int OP_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef MSEQ_SINGLE_STEP_EN
  input  logic                 step_req,
`endif
  input  logic [DATA_SIZE-1:0] instr,
  input  logic                 flag_zero,
  input  logic                 flag_carry,
  output logic [11:0]          ctrl,
  output logic [4:0]           alu_select,
  output logic                 alu_en,
  output logic                 halted
);

  // Strobe bit positions inside ctrl.
  localparam logic [11:0] PC_OUT  = 12'h001;
  localparam logic [11:0] PC_INC  = 12'h002;
  localparam logic [11:0] PC_LOAD = 12'h004;
  localparam logic [11:0] MAR_IN  = 12'h008;
  localparam logic [11:0] RAM_OUT = 12'h010;
  localparam logic [11:0] RAM_IN  = 12'h020;
  localparam logic [11:0] IR_IN   = 12'h040;
  localparam logic [11:0] IR_OUT  = 12'h080;
  localparam logic [11:0] A_IN    = 12'h100;
  localparam logic [11:0] A_OUT   = 12'h200;
  localparam logic [11:0] B_IN    = 12'h400;
  localparam logic [11:0] OUT_IN  = 12'h800;

  // ALU operation codes shared with the ALU.
  localparam logic [4:0] ALU_ADD  = 5'h02;
  localparam logic [4:0] ALU_SUB  = 5'h03;
  localparam logic [4:0] ALU_ADC  = 5'h09;
  localparam logic [4:0] ALU_AND  = 5'h0A;
  localparam logic [4:0] ALU_OR   = 5'h0B;
  localparam logic [4:0] ALU_XOR  = 5'h0C;
  localparam logic [4:0] ALU_LS   = 5'h0E;
  localparam logic [4:0] ALU_PASS = 5'h1F;

  // Opcodes.
  localparam logic [OP_WIDTH-1:0] OP_NOP = OP_WIDTH'(4'h0);
  localparam logic [OP_WIDTH-1:0] OP_LDA = OP_WIDTH'(4'h1);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(4'h2);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(4'h3);
  localparam logic [OP_WIDTH-1:0] OP_STA = OP_WIDTH'(4'h4);
  localparam logic [OP_WIDTH-1:0] OP_LDI = OP_WIDTH'(4'h5);
  localparam logic [OP_WIDTH-1:0] OP_JMP = OP_WIDTH'(4'h6);
  localparam logic [OP_WIDTH-1:0] OP_JC  = OP_WIDTH'(4'h7);
  localparam logic [OP_WIDTH-1:0] OP_JZ  = OP_WIDTH'(4'h8);
  localparam logic [OP_WIDTH-1:0] OP_ADC = OP_WIDTH'(4'h9);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(4'hA);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(4'hB);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4'hC);
  localparam logic [OP_WIDTH-1:0] OP_OUT = OP_WIDTH'(4'hD);
  localparam logic [OP_WIDTH-1:0] OP_SHL = OP_WIDTH'(4'hE);
  localparam logic [OP_WIDTH-1:0] OP_HLT = OP_WIDTH'(4'hF);

  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_HALT = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic                  zf_q, zf_d;
  logic                  cf_q, cf_d;
  logic [OP_WIDTH-1:0]   opcode;
  logic                  is_alu2;   // two-operand ALU op (memory operand into B)
  logic                  is_arith;  // ALU op that updates carry
  logic [4:0]            op_alu_code;
  logic                  unused_operand;

`ifdef MSEQ_SINGLE_STEP_EN
  logic                  go_q, go_d;
`endif

  assign opcode         = instr[DATA_SIZE-1 -: OP_WIDTH];
  // The operand bits go straight to the bus through ir_out, never into decode.
  assign unused_operand = ^instr[DATA_SIZE-OP_WIDTH-1:0];

  always_comb begin
    is_alu2     = 1'b0;
    is_arith    = 1'b0;
    op_alu_code = ALU_PASS;
    case (opcode)
      OP_ADD:  begin is_alu2 = 1'b1; is_arith = 1'b1; op_alu_code = ALU_ADD; end
      OP_SUB:  begin is_alu2 = 1'b1; is_arith = 1'b1; op_alu_code = ALU_SUB; end
      OP_ADC:  begin is_alu2 = 1'b1; is_arith = 1'b1; op_alu_code = ALU_ADC; end
      OP_AND:  begin is_alu2 = 1'b1; op_alu_code = ALU_AND; end
      OP_OR:   begin is_alu2 = 1'b1; op_alu_code = ALU_OR;  end
      OP_XOR:  begin is_alu2 = 1'b1; op_alu_code = ALU_XOR; end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    zf_d       = zf_q;
    cf_d       = cf_q;
    ctrl       = '0;
    alu_en     = 1'b0;
    alu_select = ALU_PASS;
`ifdef MSEQ_SINGLE_STEP_EN
    go_d       = go_q;
`endif

    case (state_q)
      S_T0: begin
`ifdef MSEQ_SINGLE_STEP_EN
        // Idle in T0 until a step request has been sampled.
        if (!go_q) begin
          go_d = step_req;
        end else begin
          ctrl    = PC_OUT | MAR_IN;
          state_d = S_T1;
          go_d    = 1'b0;
        end
`else
        ctrl    = PC_OUT | MAR_IN;
        state_d = S_T1;
`endif
      end

      S_T1: begin
        ctrl    = RAM_OUT | IR_IN | PC_INC;
        // NOP has no execute steps, so the fetch returns straight to T0.
        state_d = (opcode == OP_NOP) ? S_T0 : S_T2;
      end

      S_T2: begin
        state_d = S_T0;
        if (is_alu2 || opcode == OP_LDA || opcode == OP_STA) begin
          ctrl    = IR_OUT | MAR_IN;
          state_d = S_T3;
        end else begin
          case (opcode)
            OP_SHL: begin
              alu_select = ALU_LS;
              state_d    = S_T3;
            end
            OP_LDI:  ctrl = IR_OUT | A_IN;
            OP_JMP:  ctrl = IR_OUT | PC_LOAD;
            OP_JC:   ctrl = cf_q ? (IR_OUT | PC_LOAD) : '0;
            OP_JZ:   ctrl = zf_q ? (IR_OUT | PC_LOAD) : '0;
            OP_OUT:  ctrl = A_OUT | OUT_IN;
            OP_HLT:  state_d = S_HALT;
            default: ;
          endcase
        end
      end

      S_T3: begin
        state_d = S_T0;
        if (is_alu2) begin
          ctrl    = RAM_OUT | B_IN;
          state_d = S_T4;
        end else begin
          case (opcode)
            OP_LDA: ctrl = RAM_OUT | A_IN;
            OP_STA: ctrl = A_OUT | RAM_IN;
            OP_SHL: begin
              // Shift result was registered at the end of T2.
              ctrl   = A_IN;
              alu_en = 1'b1;
              zf_d   = flag_zero;
              cf_d   = flag_carry;
            end
            default: ;
          endcase
        end
      end

      S_T4: begin
        // The ALU registers its result at the end of this step.
        alu_select = op_alu_code;
        state_d    = S_T5;
      end

      S_T5: begin
        ctrl    = A_IN;
        alu_en  = 1'b1;
        zf_d    = flag_zero;
        // Logic ops leave the carry from the last arithmetic op intact.
        if (is_arith) begin
          cf_d = flag_carry;
        end
        state_d = S_T0;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_T0;
    endcase

    if (rst) begin
      ctrl       = '0;
      alu_en     = 1'b0;
      alu_select = ALU_PASS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_T0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
`ifdef MSEQ_SINGLE_STEP_EN
      go_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
`ifdef MSEQ_SINGLE_STEP_EN
      go_q    <= go_d;
`endif
    end
  end

  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - scoreboard bench for micro_sequencer

module tb_micro_sequencer;

  localparam logic [11:0] PC_OUT  = 12'h001;
  localparam logic [11:0] PC_INC  = 12'h002;
  localparam logic [11:0] PC_LOAD = 12'h004;
  localparam logic [11:0] MAR_IN  = 12'h008;
  localparam logic [11:0] RAM_OUT = 12'h010;
  localparam logic [11:0] RAM_IN  = 12'h020;
  localparam logic [11:0] IR_IN   = 12'h040;
  localparam logic [11:0] IR_OUT  = 12'h080;
  localparam logic [11:0] A_IN    = 12'h100;
  localparam logic [11:0] A_OUT   = 12'h200;
  localparam logic [11:0] B_IN    = 12'h400;
  localparam logic [11:0] OUT_IN  = 12'h800;
  localparam logic [4:0]  PASS    = 5'h1F;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  instr;
  logic        flag_zero, flag_carry;
  logic [11:0] ctrl;
  logic [4:0]  alu_select;
  logic        alu_en, halted;
`ifdef MSEQ_SINGLE_STEP_EN
  logic        step_req;
`endif

  micro_sequencer dut (
    .clk        (clk),
    .rst        (rst),
`ifdef MSEQ_SINGLE_STEP_EN
    .step_req   (step_req),
`endif
    .instr      (instr),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .ctrl       (ctrl),
    .alu_select (alu_select),
    .alu_en     (alu_en),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] c;
    logic        e;
    logic [4:0]  s;
    logic        h;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic m_zf  = 1'b0;
  logic m_cf  = 1'b0;

  function automatic logic [4:0] alu_code(input logic [3:0] op);
    case (op)
      4'h2: return 5'h02;
      4'h3: return 5'h03;
      4'h9: return 5'h09;
      4'hA: return 5'h0A;
      4'hB: return 5'h0B;
      4'hC: return 5'h0C;
      default: return PASS;
    endcase
  endfunction

  // Cycles per instruction including the two fetch steps.
  function automatic int n_cycles(input logic [3:0] op);
    case (op)
      4'h0: return 2;
      4'h1, 4'h4, 4'hE: return 4;
      4'h2, 4'h3, 4'h9, 4'hA, 4'hB, 4'hC: return 6;
      default: return 3;
    endcase
  endfunction

  function automatic logic is_alu2(input logic [3:0] op);
    return (op == 4'h2 || op == 4'h3 || op == 4'h9 || op == 4'hA || op == 4'hB || op == 4'hC);
  endfunction

  // Reference: strobes for step k of instruction op; updates model flags.
  task automatic model_step(input logic [3:0] op, input int k, input logic z, input logic cy,
                            output logic [11:0] c, output logic e, output logic [4:0] s);
    c = '0; e = 1'b0; s = PASS;
    if (k == 0) c = PC_OUT | MAR_IN;
    else if (k == 1) c = RAM_OUT | IR_IN | PC_INC;
    else if (is_alu2(op)) begin
      case (k)
        2: c = IR_OUT | MAR_IN;
        3: c = RAM_OUT | B_IN;
        4: s = alu_code(op);
        default: begin
          c = A_IN; e = 1'b1; m_zf = z;
          if (op == 4'h2 || op == 4'h3 || op == 4'h9) m_cf = cy;
        end
      endcase
    end else begin
      case (op)
        4'h1: c = (k == 2) ? (IR_OUT | MAR_IN) : (RAM_OUT | A_IN);
        4'h4: c = (k == 2) ? (IR_OUT | MAR_IN) : (A_OUT | RAM_IN);
        4'h5: c = IR_OUT | A_IN;
        4'h6: c = IR_OUT | PC_LOAD;
        4'h7: c = m_cf ? (IR_OUT | PC_LOAD) : 12'h000;
        4'h8: c = m_zf ? (IR_OUT | PC_LOAD) : 12'h000;
        4'hD: c = A_OUT | OUT_IN;
        4'hE: if (k == 2) s = 5'h0E;
              else begin c = A_IN; e = 1'b1; m_zf = z; m_cf = cy; end
        default: ;
      endcase
    end
  endtask

  task automatic next();
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef MSEQ_SINGLE_STEP_EN
    step_req = 1'b0;
`endif
  endtask

  task automatic expect_out(input logic [11:0] c, input logic e, input logic [4:0] s, input logic h);
    exp_t x;
    x.c = c; x.e = e; x.s = s; x.h = h;
    sb.push_back(x);
  endtask

  task automatic start_gap();
`ifdef MSEQ_SINGLE_STEP_EN
    next();
    step_req = 1'b1;
    expect_out('0, 1'b0, PASS, 1'b0);
`endif
  endtask

  // fl < 0: random flags each cycle; otherwise fl[1]=zero, fl[0]=carry.
  task automatic run_instr(input logic [7:0] ins, input int rst_at, input int fl);
    logic [3:0]  op;
    logic [11:0] c;
    logic        e, z, cy;
    logic [4:0]  s;
    int          n;
    op = ins[7:4];
    n  = n_cycles(op);
    start_gap();
    for (int k = 0; k < n; k++) begin
      next();
      instr = ins;
      if (fl < 0) {z, cy} = 2'($urandom_range(0, 3));
      else        {z, cy} = 2'(fl);
      flag_zero  = z;
      flag_carry = cy;
      if (k == rst_at) begin
        rst = 1'b1;
        expect_out('0, 1'b0, PASS, 1'b0);
        m_zf = 1'b0;
        m_cf = 1'b0;
        return;
      end
      model_step(op, k, z, cy, c, e, s);
      expect_out(c, e, s, 1'b0);
    end
  endtask

  task automatic run_hlt();
    run_instr(8'hF0, -1, -1);
    repeat (20) begin
      next();
      flag_zero  = 1'($urandom_range(0, 1));
      flag_carry = 1'($urandom_range(0, 1));
      expect_out('0, 1'b0, PASS, 1'b1);
    end
    next();
    rst = 1'b1;
    expect_out('0, 1'b0, PASS, 1'b1);
    m_zf = 1'b0;
    m_cf = 1'b0;
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        total += 4;
        if (ctrl !== x.c) begin
          bad++; $display("FAIL ctrl cyc=%0d got=%h want=%h", cyc, ctrl, x.c);
        end
        if (alu_en !== x.e) begin
          bad++; $display("FAIL alu_en cyc=%0d got=%b want=%b", cyc, alu_en, x.e);
        end
        if (alu_select !== x.s) begin
          bad++; $display("FAIL alu_select cyc=%0d got=%h want=%h", cyc, alu_select, x.s);
        end
        if (halted !== x.h) begin
          bad++; $display("FAIL halted cyc=%0d got=%b want=%b", cyc, halted, x.h);
        end
      end
    end
  end

  initial begin
    logic [7:0] ins;
    logic [3:0] op;
    int         ra;
    rst = 1'b1; instr = '0; flag_zero = 1'b0; flag_carry = 1'b0;
`ifdef MSEQ_SINGLE_STEP_EN
    step_req = 1'b0;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    expect_out('0, 1'b0, PASS, 1'b0);

`ifdef MSEQ_SINGLE_STEP_EN
    repeat (10) begin
      next();
      expect_out('0, 1'b0, PASS, 1'b0);
    end
`endif

    run_instr(8'h57, -1, -1);       // LDI 7
    run_instr(8'h2A, -1, 3);        // ADD, zero=1 carry=1
    run_instr(8'h73, -1, -1);       // JC taken
    run_instr(8'hA1, -1, 0);        // AND latches zf=0, cf stays 1
    run_instr(8'h84, -1, -1);       // JZ not taken
    run_instr(8'h70, -1, -1);       // JC still taken
    run_hlt();
    run_instr(8'h2B, -1, 3);        // set both flags
    run_instr(8'h35, 4, 3);         // reset during SUB T4
    run_instr(8'h80, -1, -1);
    run_instr(8'h70, -1, -1);
    run_instr(8'h2B, -1, 3);
    run_instr(8'h35, 5, 3);         // reset during SUB T5: no flag latch
    run_instr(8'h80, -1, -1);
    run_instr(8'h70, -1, -1);
    run_instr(8'hE0, -1, 2);        // SHL latches zf=1 cf=0
    run_instr(8'h80, -1, -1);
    run_instr(8'h70, -1, -1);

    for (int i = 0; i < 250; i++) begin
      ins = 8'($urandom_range(0, 255));
      op  = ins[7:4];
      if (op == 4'hF) begin
        if (i % 50 == 0) begin
          run_hlt();
          continue;
        end
        ins[7:4] = 4'(i % 15);
        op = ins[7:4];
      end
      ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, n_cycles(op) - 1)) : -1;
      run_instr(ins, ra, -1);
    end

    next();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
